// File: rtl/ahb_switch_in.sv
// ahb_switch_in
// ---------------------------------------------------------------------------
// AHB-Lite slave for a bank of WIDTH on-board switches. Each channel goes
// through a 2-FF synchroniser and a per-channel debounce counter. Software
// reads the synchronised raw value and the debounced value. Debounced edges
// are latched into a write-1-to-clear STATUS register, masked by IRQ_EN, and
// OR-reduced into one registered level interrupt.
//
// Register map (word offset from HADDR[4:2]):
//   0x00 DATA     RO  debounced switch value
//   0x04 RAW      RO  synchronised (not debounced) switch value
//   0x08 IRQ_EN   RW  per-channel interrupt enable
//   0x0C STATUS   W1C per-channel edge event
//   0x10 EDGE_SEL RW  only with SW_EDGE_SEL_EN (0 = rising, 1 = falling)
//   Other offsets read 0 and ignore writes. Unused upper bits read 0.
//
// Optional feature macro: SW_EDGE_SEL_EN
//   Defined   -> EDGE_SEL register selects which debounced edge sets STATUS.
//   Undefined -> both edges set STATUS, offset 0x10 is unmapped.
//
// Parameters:
//   WIDTH           number of switch channels (1..32)
//   DEBOUNCE_CYCLES stable cycles required before db follows sw_s (>=2)
//   DB_RST_VAL      reset value of every debounced bit
//
// Ports:
//   clk, RSTn       clock, asynchronous active-low reset
//   SW              asynchronous switch inputs
//   HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY   AHB-Lite slave inputs
//   HREADYOUT       always 1 (zero wait states)
//   HRESP           always 0 (OKAY)
//   HRDATA          read data, combinational from the captured address
//   IRQ             registered level interrupt
// ---------------------------------------------------------------------------
module ahb_switch_in #(
   parameter int   WIDTH           = 8,
   parameter int   DEBOUNCE_CYCLES = 20000,
   parameter logic DB_RST_VAL      = 1'b0
) (
   input  logic             clk,
   input  logic             RSTn,
   input  logic [WIDTH-1:0] SW,
   input  logic             HSEL,
   input  logic [31:0]      HADDR,
   input  logic [1:0]       HTRANS,
   input  logic             HWRITE,
   input  logic [2:0]       HSIZE,
   input  logic [31:0]      HWDATA,
   input  logic             HREADY,
   output logic             HREADYOUT,
   output logic             HRESP,
   output logic [31:0]      HRDATA,
   output logic             IRQ
);

   localparam int              CW      = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [WIDTH-1:0] DB_RST = {WIDTH{DB_RST_VAL}};

   localparam logic [2:0] OFS_DATA   = 3'd0;
   localparam logic [2:0] OFS_RAW    = 3'd1;
   localparam logic [2:0] OFS_IRQ_EN = 3'd2;
   localparam logic [2:0] OFS_STATUS = 3'd3;
`ifdef SW_EDGE_SEL_EN
   localparam logic [2:0] OFS_EDGE_SEL = 3'd4;
`endif

   // synchroniser, debounce and edge-detect state
   logic [WIDTH-1:0] sync1_q, sync1_d;
   logic [WIDTH-1:0] sync2_q, sync2_d;
   logic [WIDTH-1:0] db_q, db_d;
   logic [WIDTH-1:0] db_prev_q, db_prev_d;
   logic [CW-1:0]    cnt_q [WIDTH];
   logic [CW-1:0]    cnt_d [WIDTH];

   // software-visible registers
   logic [WIDTH-1:0] irq_en_q, irq_en_d;
   logic [WIDTH-1:0] status_q, status_d;
   logic             irq_q, irq_d;
`ifdef SW_EDGE_SEL_EN
   logic [WIDTH-1:0] edge_sel_q, edge_sel_d;
`endif

   // AHB address-phase capture
   logic             ap_valid_q, ap_valid_d;
   logic             ap_write_q, ap_write_d;
   logic [2:0]       ap_addr_q, ap_addr_d;

   logic             wr_en;
   logic [WIDTH-1:0] rise, fall, ev_set, w1c;
   logic [31:0]      rd_data;
   logic             unused_bits;

   // HSIZE, the undecoded address bits and HTRANS[0] carry no meaning here.
   assign unused_bits = ^{HSIZE, HADDR[31:5], HADDR[1:0], HTRANS[0], HWDATA};

   assign HREADYOUT = 1'b1;
   assign HRESP     = 1'b0;
   assign IRQ       = irq_q;
   assign HRDATA    = rd_data;

   // The write lands on the edge that ends its data phase, i.e. when HREADY
   // is high while a captured write is pending.
   assign wr_en = ap_valid_q & ap_write_q & HREADY;

   // Synchroniser and per-channel debounce. A channel's counter only runs
   // while sw_s disagrees with db, so any return to agreement restarts it.
   always_comb begin
      sync1_d   = SW;
      sync2_d   = sync1_q;
      db_d      = db_q;
      db_prev_d = db_q;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = cnt_q[i];
         if (sync2_q[i] == db_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_MAX) begin
            db_d[i]  = sync2_q[i];
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
         end
      end
   end

   // Edge events from the debounced value and its one-cycle delayed copy.
   always_comb begin
      rise = db_q & ~db_prev_q;
      fall = ~db_q & db_prev_q;
`ifdef SW_EDGE_SEL_EN
      ev_set = (rise & ~edge_sel_q) | (fall & edge_sel_q);
`else
      ev_set = rise | fall;
`endif
   end

   // Bus capture and register updates. In STATUS the set term is OR-ed in
   // after the clear, so a new event wins over a same-cycle W1C.
   always_comb begin
      ap_valid_d = ap_valid_q;
      ap_write_d = ap_write_q;
      ap_addr_d  = ap_addr_q;
      if (HREADY) begin
         ap_valid_d = HSEL & HTRANS[1];
         if (HSEL & HTRANS[1]) begin
            ap_write_d = HWRITE;
            ap_addr_d  = HADDR[4:2];
         end
      end

      irq_en_d = irq_en_q;
      w1c      = '0;
      if (wr_en && ap_addr_q == OFS_IRQ_EN) begin
         irq_en_d = HWDATA[WIDTH-1:0];
      end
      if (wr_en && ap_addr_q == OFS_STATUS) begin
         w1c = HWDATA[WIDTH-1:0];
      end
`ifdef SW_EDGE_SEL_EN
      edge_sel_d = edge_sel_q;
      if (wr_en && ap_addr_q == OFS_EDGE_SEL) begin
         edge_sel_d = HWDATA[WIDTH-1:0];
      end
`endif

      status_d = (status_q & ~w1c) | ev_set;
      irq_d    = |(status_q & irq_en_q);
   end

   // Read mux, valid only during the data phase of a captured read.
   always_comb begin
      rd_data = '0;
      if (ap_valid_q && !ap_write_q) begin
         case (ap_addr_q)
            OFS_DATA:     rd_data = 32'(db_q);
            OFS_RAW:      rd_data = 32'(sync2_q);
            OFS_IRQ_EN:   rd_data = 32'(irq_en_q);
            OFS_STATUS:   rd_data = 32'(status_q);
`ifdef SW_EDGE_SEL_EN
            OFS_EDGE_SEL: rd_data = 32'(edge_sel_q);
`endif
            default:      rd_data = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         db_q       <= DB_RST;
         db_prev_q  <= DB_RST;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= '0;
         end
         irq_en_q   <= '0;
         status_q   <= '0;
         irq_q      <= 1'b0;
`ifdef SW_EDGE_SEL_EN
         edge_sel_q <= '0;
`endif
         ap_valid_q <= 1'b0;
         ap_write_q <= 1'b0;
         ap_addr_q  <= '0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         db_q       <= db_d;
         db_prev_q  <= db_prev_d;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         irq_en_q   <= irq_en_d;
         status_q   <= status_d;
         irq_q      <= irq_d;
`ifdef SW_EDGE_SEL_EN
         edge_sel_q <= edge_sel_d;
`endif
         ap_valid_q <= ap_valid_d;
         ap_write_q <= ap_write_d;
         ap_addr_q  <= ap_addr_d;
      end
   end

endmodule

// File: tb/tb_ahb_switch_in.sv
// tb_ahb_switch_in
// ---------------------------------------------------------------------------
// Scoreboard bench for ahb_switch_in (WIDTH=8, DEBOUNCE_CYCLES=4,
// DB_RST_VAL=0). The stimulus process issues bus cycles and switch patterns
// and pushes the expected read data (and optionally the expected IRQ level)
// into queues. The monitor watches the bus for read address phases and
// compares HRDATA/IRQ/HREADYOUT/HRESP during the following data phase.
// Build with +define+SW_EDGE_SEL_EN to exercise the EDGE_SEL register.
// ---------------------------------------------------------------------------
module tb_ahb_switch_in;

   logic        clk = 1'b0;
   logic        RSTn;
   logic [7:0]  SW;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic        HREADYOUT;
   logic        HRESP;
   logic [31:0] HRDATA;
   logic        IRQ;

   int          checks = 0;
   int          errors = 0;
   int          drain  = 0;
   logic        rdPhase = 1'b0;
   logic        rstProbe = 1'b0;
   logic        stimDone = 1'b0;

   string       nameQ[$];
   logic [31:0] dataQ[$];
   bit          irqChkQ[$];
   bit          irqExpQ[$];

   ahb_switch_in #(
      .WIDTH(8),
      .DEBOUNCE_CYCLES(4),
      .DB_RST_VAL(1'b0)
   ) dut (
      .clk(clk),
      .RSTn(RSTn),
      .SW(SW),
      .HSEL(HSEL),
      .HADDR(HADDR),
      .HTRANS(HTRANS),
      .HWRITE(HWRITE),
      .HSIZE(HSIZE),
      .HWDATA(HWDATA),
      .HREADY(HREADY),
      .HREADYOUT(HREADYOUT),
      .HRESP(HRESP),
      .HRDATA(HRDATA),
      .IRQ(IRQ)
   );

   // free-running 10-unit clock
   always #5 clk = ~clk;

   // Flag the data phase that follows every accepted read address phase.
   always @(posedge clk) begin
      rdPhase <= RSTn && HSEL && HTRANS[1] && HREADY && !HWRITE;
   end

   // Drive one bus cycle: address-phase controls plus HWDATA for the
   // previous address phase, then step past the next rising edge.
   task automatic applyStimulus(input logic sel, input logic [1:0] trans,
                                input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata);
      HSEL   = sel;
      HTRANS = trans;
      HWRITE = wr;
      HADDR  = addr;
      HWDATA = wdata;
      @(posedge clk);
      #1;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic expectRead(input string name, input logic [31:0] data,
                             input bit chkIrq, input bit irq);
      nameQ.push_back(name);
      dataQ.push_back(data);
      irqChkQ.push_back(chkIrq);
      irqExpQ.push_back(irq);
   endtask

   task automatic doWrite(input logic [31:0] addr, input logic [31:0] data);
      applyStimulus(1'b1, 2'b10, 1'b1, addr, 32'h0);
      applyStimulus(1'b0, 2'b00, 1'b0, 32'h0, data);
   endtask

   task automatic doRead(input string name, input logic [31:0] addr,
                         input logic [31:0] data, input bit chkIrq, input bit irq);
      expectRead(name, data, chkIrq, irq);
      applyStimulus(1'b1, 2'b10, 1'b0, addr, 32'h0);
      applyStimulus(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
   endtask

   // single comparison point; only the monitor calls this
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
      end
   endtask

   // Monitor: compares reset outputs when probed, pops one expectation per
   // read data phase, and ends the run once stimulus is done and drained.
   initial begin : monitor
      string       nm;
      logic [31:0] ed;
      bit          ic;
      bit          ie;
      forever begin
         @(negedge clk);
         if (rstProbe) begin
            checkOutput("rst_hrdata", HRDATA, 32'h0);
            checkOutput("rst_irq", {31'b0, IRQ}, 32'h0);
            checkOutput("rst_hreadyout", {31'b0, HREADYOUT}, 32'h1);
            checkOutput("rst_hresp", {31'b0, HRESP}, 32'h0);
         end
         if (rdPhase) begin
            if (nameQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_read: got 0x%08h expected no read", HRDATA);
            end else begin
               nm = nameQ.pop_front();
               ed = dataQ.pop_front();
               ic = irqChkQ.pop_front();
               ie = irqExpQ.pop_front();
               checkOutput(nm, HRDATA, ed);
               checkOutput({nm, "_hreadyout"}, {31'b0, HREADYOUT}, 32'h1);
               checkOutput({nm, "_hresp"}, {31'b0, HRESP}, 32'h0);
               if (ic) checkOutput({nm, "_irq"}, {31'b0, IRQ}, {31'b0, ie});
            end
         end
         if (stimDone) begin
            if (nameQ.size() == 0 || drain >= 20) begin
               if (nameQ.size() != 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL drain_timeout: got %0d pending reads expected 0", nameQ.size());
               end
               $display("CHECKS %0d ERRORS %0d", checks, errors);
               $finish;
            end
            drain++;
         end
      end
   end

   // Directed stimulus. Switch changes are made just after a rising edge;
   // db follows 6 edges later, STATUS one edge after that, IRQ one more.
   initial begin : stimulus
      RSTn   = 1'b0;
      SW     = 8'hAA;
      HSEL   = 1'b0;
      HADDR  = 32'h0;
      HTRANS = 2'b00;
      HWRITE = 1'b0;
      HSIZE  = 3'b010;
      HWDATA = 32'h0;
      HREADY = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rstProbe = 1'b1;
      @(posedge clk);
      #1;
      rstProbe = 1'b0;
      RSTn = 1'b1;
      $display("[TB] reset released");

      // reset value, then the switches qualify through sync + debounce
      doRead("rst_data", 32'h00, 32'h00, 1'b1, 1'b0);
      doRead("rst_raw", 32'h04, 32'hAA, 1'b0, 1'b0);
      idleCycles(4);
      doRead("post_rst_data", 32'h00, 32'hAA, 1'b0, 1'b0);
      doRead("post_rst_status", 32'h0C, 32'hAA, 1'b1, 1'b0);
      doRead("post_rst_raw", 32'h04, 32'hAA, 1'b0, 1'b0);

      // 3-cycle glitch on SW[0] is rejected
      SW = 8'hAB; idleCycles(3); SW = 8'hAA; idleCycles(10);
      doRead("glitch3_data", 32'h00, 32'hAA, 1'b0, 1'b0);
      doRead("glitch3_status", 32'h0C, 32'hAA, 1'b0, 1'b0);

      // 6-cycle pulse qualifies, then the release qualifies too
      SW = 8'hAB; idleCycles(6); SW = 8'hAA;
      doRead("pulse6_high", 32'h00, 32'hAB, 1'b0, 1'b0);
      idleCycles(10);
      doRead("pulse6_low", 32'h00, 32'hAA, 1'b0, 1'b0);
      doRead("pulse6_status", 32'h0C, 32'hAB, 1'b0, 1'b0);

      // exactly DEBOUNCE_CYCLES of stable input is enough
      doWrite(32'h0C, 32'hFF);
      SW = 8'hAB; idleCycles(4); SW = 8'hAA; idleCycles(10);
      doRead("pulse4_status", 32'h0C, 32'h01, 1'b0, 1'b0);

      // IRQ path
      doWrite(32'h08, 32'h01);
      doWrite(32'h0C, 32'hFF);
      doRead("irq_clr_status", 32'h0C, 32'h00, 1'b1, 1'b0);
      SW = 8'hAB; idleCycles(8);
      doRead("irq_status", 32'h0C, 32'h01, 1'b1, 1'b1);
      doWrite(32'h0C, 32'h01);
      doRead("irq_w1c_status", 32'h0C, 32'h00, 1'b1, 1'b0);
      doRead("irq_data", 32'h00, 32'hAB, 1'b0, 1'b0);

      // clearing IRQ_EN masks IRQ but keeps STATUS
      SW = 8'hAA; idleCycles(8);
      doRead("mask_pre_status", 32'h0C, 32'h01, 1'b1, 1'b1);
      doWrite(32'h08, 32'h00);
      doRead("mask_status", 32'h0C, 32'h01, 1'b1, 1'b0);

      // W1C on STATUS[1] lands on the edge where the event sets it
      doWrite(32'h0C, 32'hFF);
      doRead("coll_pre_status", 32'h0C, 32'h00, 1'b0, 1'b0);
      SW = 8'hA8; idleCycles(5);
      doWrite(32'h0C, 32'h02);
      doRead("coll_status", 32'h0C, 32'h02, 1'b0, 1'b0);

      // back-to-back write then read of IRQ_EN
      applyStimulus(1'b1, 2'b10, 1'b1, 32'h08, 32'h0);
      expectRead("b2b_irq_en", 32'h5A, 1'b0, 1'b0);
      applyStimulus(1'b1, 2'b10, 1'b0, 32'h08, 32'h5A);
      applyStimulus(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
      doRead("b2b_irq_level", 32'h0C, 32'h02, 1'b1, 1'b1);

      // IDLE and BUSY transfers are not captured
      applyStimulus(1'b1, 2'b00, 1'b1, 32'h08, 32'h0);
      applyStimulus(1'b1, 2'b01, 1'b1, 32'h08, 32'h0);
      applyStimulus(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
      doRead("idle_irq_en", 32'h08, 32'h5A, 1'b0, 1'b0);

      // upper bits read 0, unmapped offsets read 0 and ignore writes
      doWrite(32'h08, 32'hFFFF_FFFF);
      doRead("upper_irq_en", 32'h08, 32'hFF, 1'b0, 1'b0);
      doWrite(32'h18, 32'hFFFF_FFFF);
      doRead("unmapped_18", 32'h18, 32'h0, 1'b0, 1'b0);
      doRead("unmapped_14", 32'h14, 32'h0, 1'b0, 1'b0);
      doRead("unmapped_1c", 32'h1C, 32'h0, 1'b0, 1'b0);
      doWrite(32'h08, 32'h00);

`ifdef SW_EDGE_SEL_EN
      // falling-edge select on channel 0
      doWrite(32'h10, 32'h01);
      doRead("edge_sel_reg", 32'h10, 32'h01, 1'b0, 1'b0);
      doWrite(32'h0C, 32'hFF);
      SW = 8'hA9; idleCycles(8);
      doRead("edge_sel_rise", 32'h0C, 32'h00, 1'b0, 1'b0);
      SW = 8'hA8; idleCycles(8);
      doRead("edge_sel_fall", 32'h0C, 32'h01, 1'b0, 1'b0);
`else
      // offset 0x10 is unmapped and both edges set STATUS
      doWrite(32'h10, 32'hFF);
      doRead("unmapped_10", 32'h10, 32'h0, 1'b0, 1'b0);
      doWrite(32'h0C, 32'hFF);
      SW = 8'hA9; idleCycles(8);
      doRead("both_edge_rise", 32'h0C, 32'h01, 1'b0, 1'b0);
`endif

      $display("[TB] stimulus complete");
      stimDone = 1'b1;
   end

endmodule
